ahb3lite_apb_bridge: RTL

//  AHB3-Lite slave to APB master bridge. Converts each accepted AHB transfer into one APB

---
 rtl/ahb3lite_apb_bridge_if.sv | 57 +++++
 rtl/ahb3lite_apb_bridge.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ahb3lite_apb_bridge_if.sv
// Bus bundles for the AHB3-Lite to APB bridge.
// ahb3lite_if carries the AHB3-Lite slave port; apb_if carries the APB master port.

interface ahb3lite_if #(
  parameter int unsigned HADDR_SIZE = 32,
  parameter int unsigned HDATA_SIZE = 32
);
  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HMASTLOCK;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

interface apb_if #(
  parameter int unsigned PADDR_SIZE = 8,
  parameter int unsigned PDATA_SIZE = 32
);
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [2:0]              PPROT;
  logic [PDATA_SIZE/8-1:0] PSTRB;
  logic [PADDR_SIZE-1:0]   PADDR;
  logic [PDATA_SIZE-1:0]   PWDATA;
  logic [PDATA_SIZE-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PPROT, PSTRB, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PPROT, PSTRB, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/ahb3lite_apb_bridge.sv
// AHB3-Lite slave to APB master bridge: one APB SETUP/ACCESS sequence per accepted AHB
// transfer, with the AHB data phase stalled until the APB side completes.

module ahb3lite_apb_bridge #(
  parameter int unsigned HADDR_SIZE = 32,
  parameter int unsigned HDATA_SIZE = 32,
  parameter int unsigned PADDR_SIZE = 8,
  parameter int unsigned PDATA_SIZE = 32
) (
  input  logic      HCLK,
  input  logic      HRESET,
  ahb3lite_if.slave ahb,
  apb_if.master     apb
);

  localparam int unsigned STRB_W   = PDATA_SIZE / 8;
  localparam int unsigned LSB_W    = $clog2(STRB_W);
  localparam int unsigned MAX_SIZE = $clog2(HDATA_SIZE / 8);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t state_q, state_d;

  logic accept_c;
  logic size_err_c;
  logic start_c;
  logic read_done_c;

  logic hreadyout_d, hresp_d, psel_d, penable_d;

  logic                  hreadyout_q;
  logic                  hresp_q;
  logic [HDATA_SIZE-1:0] hrdata_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [2:0]            pprot_q;
  logic [STRB_W-1:0]     pstrb_q;
  logic [PADDR_SIZE-1:0] paddr_q;
  logic [PDATA_SIZE-1:0] pwdata_q;

  // Byte lanes covered by a naturally aligned access of 2**size bytes at byte offset lsb
  function automatic logic [STRB_W-1:0] byte_strobe(input logic [2:0] size,
                                                     input logic [LSB_W-1:0] lsb);
    logic [STRB_W-1:0] strb;
    strb = '0;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      strb[i] = ((i >> size) == (32'(lsb) >> size));
    end
    return strb;
  endfunction

  assign accept_c    = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
  assign size_err_c  = (ahb.HSIZE > 3'(MAX_SIZE));
  assign read_done_c = (state_q == ST_ACCESS) & apb.PREADY & ~apb.PSLVERR & ~pwrite_q;

  // Next state and the next value of each registered handshake output
  always_comb begin
    state_d     = state_q;
    start_c     = 1'b0;
    hreadyout_d = 1'b1;
    hresp_d     = 1'b0;
    psel_d      = 1'b0;
    penable_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept_c) begin
          if (size_err_c) begin
            state_d = ST_ERR1;
          end else begin
            start_c = 1'b1;
            state_d = ahb.HWRITE ? ST_WDATA : ST_SETUP;
          end
        end
      end
      ST_WDATA:  state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (apb.PREADY) begin
          state_d = apb.PSLVERR ? ST_ERR1 : ST_IDLE;
        end
      end
      ST_ERR1:   state_d = ST_ERR2;
      default:   state_d = ST_IDLE;
    endcase

    hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
    hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
    psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d   = (state_d == ST_ACCESS);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output registers; APB address/control are captured only when an APB access starts
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pprot_q     <= '0;
      pstrb_q     <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      if (start_c) begin
        paddr_q  <= ahb.HADDR[PADDR_SIZE-1:0];
        pwrite_q <= ahb.HWRITE;
        pprot_q  <= {~ahb.HPROT[0], 1'b0, ahb.HPROT[1]};
        pstrb_q  <= ahb.HWRITE ? byte_strobe(ahb.HSIZE, ahb.HADDR[LSB_W-1:0]) : '0;
      end
      if (state_q == ST_WDATA) begin
        pwdata_q <= ahb.HWDATA;
      end
      if (read_done_c) begin
        hrdata_q <= apb.PRDATA;
      end
    end
  end

  assign ahb.HREADYOUT = hreadyout_q;
  assign ahb.HRESP     = hresp_q;
  assign ahb.HRDATA    = hrdata_q;
  assign apb.PSEL      = psel_q;
  assign apb.PENABLE   = penable_q;
  assign apb.PWRITE    = pwrite_q;
  assign apb.PPROT     = pprot_q;
  assign apb.PSTRB     = pstrb_q;
  assign apb.PADDR     = paddr_q;
  assign apb.PWDATA    = pwdata_q;

  // Inputs the bridge deliberately does not act on
  logic unused_inputs;
  assign unused_inputs = ^{ahb.HBURST, ahb.HMASTLOCK, ahb.HTRANS[0], ahb.HPROT[3:2],
                           ahb.HADDR[HADDR_SIZE-1:PADDR_SIZE]};

endmodule
